// File: rtl/caravel_wb_initiator.sv
// Wishbone B4 classic initiator: turns single valid/ready commands into one
// bus transfer each and returns exactly one response, with a per-transfer timeout.
module caravel_wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        accept, bus_ack, bus_to, rsp_done;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign bus_ack   = (state == BUS) & wbm_ack_i;
    // ack takes priority over a timeout landing on the same cycle
    assign bus_to    = (state == BUS) & ~wbm_ack_i & (cnt == TO_LAST);
    assign rsp_done  = (state == RESP) & rsp_valid & rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)           state_nxt = BUS;
            BUS:     if (bus_ack | bus_to) state_nxt = RESP;
            RESP:    if (rsp_done)         state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                wbm_sel_o <= cmd_sel;
                cnt       <= '0;
            end
            if (bus_ack) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
            end else if (bus_to) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_dat   <= 32'hFFFF_FFFF;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end else if (state == BUS && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            // rsp_dat/rsp_err keep their last values once consumed
            if (rsp_done) rsp_valid <= 1'b0;
        end
    end

endmodule
